// File: rtl/oam_dma_if.sv
// Byte-wide memory bus. The master drives address, strobes and write data.
// The slave returns read data and, on the CPU side, the RDY stall.
interface oam_dma_if;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        wen;
  logic        ren;
  logic [7:0]  din;
  logic        rdy;

  modport master (output addr, dout, wen, ren, input din);
  modport slave  (input addr, dout, wen, ren, output din, rdy);
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller and CPU/system-bus arbiter; the CPU bus passes through unless a page copy to OAM is running.
// Define OAM_DMA_ALIGN_EN to add the parity flop and ALIGN state so READ always starts on a "get" cycle.
//
// state | meaning
// IDLE  | CPU owns the bus, pass-through, waiting for a write to DMA_REG_ADDR
// HALT  | RDY low, CPU still driving its pending writes
// ALIGN | one dead cycle so the first READ lands on parity 0 (OAM_DMA_ALIGN_EN only)
// READ  | fetch byte {page, idx} into latch
// WRITE | store latch to OAM_DATA_ADDR, advance idx
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic             clk,
  input  logic             rst,
  oam_dma_if.slave         cpu,
  oam_dma_if.master        bus,
  output logic             dma_busy
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
  typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       trigger;

  assign trigger  = cpu.wen && (cpu.addr == DMA_REG_ADDR);
  assign cpu.din  = bus.din;
  assign cpu.rdy  = (state == IDLE);
  assign dma_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        page <= 8'h00;
    else if (state == IDLE && trigger) page <= cpu.dout;
  end

  // A reset mid-transfer drops idx so the next trigger restarts at byte 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 idx <= 8'h00;
    else if (state == WRITE) idx <= (idx == LAST_IDX) ? 8'h00 : idx + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                latch <= 8'h00;
    else if (state == READ) latch <= bus.din;
  end

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else     parity <= ~parity;
  end
`endif

  always_comb begin
    state_nxt = state;
    bus.addr  = cpu.addr;
    bus.dout  = cpu.dout;
    bus.wen   = cpu.wen;
    bus.ren   = cpu.ren;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = HALT;
      end
      HALT: begin
        // 6502 ignores RDY on writes, so wait for the first non-write cycle.
        if (!cpu.wen) begin
`ifdef OAM_DMA_ALIGN_EN
          state_nxt = parity ? READ : ALIGN;
`else
          state_nxt = READ;
`endif
        end
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: begin
        bus.addr  = {page, idx};
        bus.dout  = latch;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        state_nxt = READ;
      end
`endif
      READ: begin
        bus.addr  = {page, idx};
        bus.dout  = latch;
        bus.wen   = 1'b0;
        bus.ren   = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        bus.addr  = OAM_DATA_ADDR;
        bus.dout  = latch;
        bus.wen   = 1'b1;
        bus.ren   = 1'b0;
        state_nxt = (idx == LAST_IDX) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
